// File: rtl/voda_lane_scheduler.sv
// -----------------------------------------------------------------------------
// voda_lane_scheduler
//   Shares one valid/ready event-report channel among N_LANES detector lanes.
//   Each lane's 1-cycle detect pulses are queued in a saturating pending
//   counter. A round-robin arbiter offers one lane at a time on the event bus,
//   and the block keeps a wrapping count of accepted events.
//
//   Optional feature: define VODA_SCHED_TIMESTAMP_EN to add a free-running
//   TS_W timer. The timer value is latched into o_ev_ts when an event is
//   offered. When the macro is undefined, the TS_W parameter, the o_ev_ts port
//   and the timer are all absent.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_lane_det    per-lane detect pulse (one cycle per user)
//   i_lane_en     per-lane enable, masks new detections only
//   i_flush       synchronous clear of pending/overflow state and the FSM
//   o_ev_valid    event offered on the bus
//   i_ev_ready    downstream accepts the offered event
//   o_ev_lane     lane id of the offered event
//   o_total_count accepted events since reset (wraps)
//   o_overflow    sticky per-lane flag: a detection was lost at saturation
//   o_busy        FSM not idle, or any lane has pending events
//   o_ev_ts       timestamp of the offered event (macro builds only)
// -----------------------------------------------------------------------------
module voda_lane_scheduler #(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned PEND_W  = 3,
   parameter int unsigned CNT_W   = 10,
`ifdef VODA_SCHED_TIMESTAMP_EN
   parameter int unsigned TS_W    = 16,
`endif
   localparam int unsigned LW     = $clog2(N_LANES)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_LANES-1:0] i_lane_det,
   input  logic [N_LANES-1:0] i_lane_en,
   input  logic               i_flush,
   output logic               o_ev_valid,
   input  logic               i_ev_ready,
   output logic [LW-1:0]      o_ev_lane,
   output logic [CNT_W-1:0]   o_total_count,
   output logic [N_LANES-1:0] o_overflow,
   output logic               o_busy
`ifdef VODA_SCHED_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]    o_ev_ts
`endif
);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_load;
   logic               w_accept;
   logic [N_LANES-1:0] w_nz;
   logic [LW-1:0]      w_pick;
   logic               w_found;

   logic [PEND_W-1:0]  r_pend [N_LANES];
   logic [N_LANES-1:0] r_overflow;
   logic [LW-1:0]      r_ev_lane;
   logic [LW-1:0]      r_last_grant;
   logic [CNT_W-1:0]   r_total;

   assign w_accept = (r_state == S_OFFER) & i_ev_ready;

   always_comb begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
         w_nz[i] = (r_pend[i] != '0);
      end
   end

   // Search starts one past the last grant, so the most recently served lane
   // is checked last.
   always_comb begin
      logic [LW-1:0] v_lane;
      w_pick  = '0;
      w_found = 1'b0;
      v_lane  = '0;
      for (int unsigned k = 1; k <= N_LANES; k++) begin
         v_lane = LW'((32'(r_last_grant) + k) % N_LANES);
         if (!w_found && w_nz[v_lane]) begin
            w_pick  = v_lane;
            w_found = 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state; flush overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_OFFER;
               w_load      = 1'b1;
            end
         end
         S_OFFER: begin
            if (i_ev_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (i_flush) begin
         w_state_nxt = S_IDLE;
         w_load      = 1'b0;
      end
   end

   // Per-lane pending counters. A same-cycle increment and decrement cancel.
   // An increment at saturation is lost and recorded in the overflow flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < N_LANES; i++) r_pend[i] <= '0;
         r_overflow <= '0;
      end else if (i_flush) begin
         for (int unsigned i = 0; i < N_LANES; i++) r_pend[i] <= '0;
         r_overflow <= '0;
      end else begin
         for (int unsigned i = 0; i < N_LANES; i++) begin
            if ((i_lane_det[i] & i_lane_en[i]) && !(w_accept && r_ev_lane == LW'(i))) begin
               if (r_pend[i] == '1) r_overflow[i] <= 1'b1;
               else                 r_pend[i]     <= r_pend[i] + 1'b1;
            end else if (!(i_lane_det[i] & i_lane_en[i]) && (w_accept && r_ev_lane == LW'(i))) begin
               r_pend[i] <= r_pend[i] - 1'b1;
            end
         end
      end
   end

   // Grant and counters. A handshake in a flush cycle still counts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ev_lane    <= '0;
         r_last_grant <= LW'(N_LANES - 1);
         r_total      <= '0;
      end else begin
         if (w_load) r_ev_lane <= w_pick;
         if (w_accept) begin
            r_total      <= r_total + 1'b1;
            r_last_grant <= r_ev_lane;
         end
      end
   end

`ifdef VODA_SCHED_TIMESTAMP_EN
   logic [TS_W-1:0] r_timer;
   logic [TS_W-1:0] r_ev_ts;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_timer <= '0;
         r_ev_ts <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
         if (w_load) r_ev_ts <= r_timer;
      end
   end

   assign o_ev_ts = r_ev_ts;
`endif

   assign o_ev_valid    = (r_state == S_OFFER);
   assign o_ev_lane     = r_ev_lane;
   assign o_total_count = r_total;
   assign o_overflow    = r_overflow;
   assign o_busy        = (r_state != S_IDLE) | w_found;

endmodule

// File: tb/tb_voda_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voda_lane_scheduler
//   Directed stimulus for voda_lane_scheduler. Stimulus pushes the expected
//   lane of every event into a queue. A negedge monitor pops the queue and
//   compares it on each handshake. The monitor also checks that o_ev_lane
//   holds steady while an offer is stalled.
// -----------------------------------------------------------------------------
module tb_voda_lane_scheduler;

   localparam int unsigned N_LANES = 4;
   localparam int unsigned CNT_W   = 10;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N_LANES-1:0] i_lane_det;
   logic [N_LANES-1:0] i_lane_en;
   logic               i_flush;
   logic               i_ev_ready;
   logic               o_ev_valid;
   logic [1:0]         o_ev_lane;
   logic [CNT_W-1:0]   o_total_count;
   logic [N_LANES-1:0] o_overflow;
   logic               o_busy;
`ifdef VODA_SCHED_TIMESTAMP_EN
   logic [15:0]        o_ev_ts;
`endif

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   voda_lane_scheduler #(
      .N_LANES(N_LANES),
      .PEND_W (3),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_lane_det   (i_lane_det),
      .i_lane_en    (i_lane_en),
      .i_flush      (i_flush),
      .o_ev_valid   (o_ev_valid),
      .i_ev_ready   (i_ev_ready),
      .o_ev_lane    (o_ev_lane),
      .o_total_count(o_total_count),
      .o_overflow   (o_overflow),
      .o_busy       (o_busy)
`ifdef VODA_SCHED_TIMESTAMP_EN
      ,
      .o_ev_ts      (o_ev_ts)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (o_busy && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (o_busy) begin
         errors++;
         $display("FAIL drain_timeout: busy still %0d after %0d cycles, required 0", o_busy, budget);
      end
   endtask

   // scoreboard monitor
   logic       held_valid = 1'b0;
   logic [1:0] held_lane  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         held_valid = 1'b0;
      end else if (o_ev_valid) begin
         if (held_valid) chk("lane_stable", o_ev_lane, held_lane);
         if (i_ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got lane %0d, required no event", o_ev_lane);
            end else begin
               int e;
               e = exp_q.pop_front();
               checks--;
               chk("ev_lane", o_ev_lane, e);
            end
            held_valid = 1'b0;
         end else begin
            held_valid = 1'b1;
            held_lane  = o_ev_lane;
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int vt[8];
      int nv;

      rst_n      = 1'b0;
      i_lane_det = '0;
      i_lane_en  = '1;
      i_flush    = 1'b0;
      i_ev_ready = 1'b0;

      // reset state
      tick(2);
      chk("rst_valid", o_ev_valid, 0);
      chk("rst_total", o_total_count, 0);
      chk("rst_overflow", o_overflow, 0);
      chk("rst_busy", o_busy, 0);
      rst_n = 1'b1;
      tick(3);

      // 1: single pulse latency
      i_ev_ready = 1'b1;
      i_lane_det = 4'b0100;
      exp_q.push_back(2);
      tick(1);
      i_lane_det = '0;
      chk("t1_valid_t1", o_ev_valid, 0);
      chk("t1_busy_t1", o_busy, 1);
      tick(1);
      chk("t1_valid_t2", o_ev_valid, 1);
      chk("t1_lane_t2", o_ev_lane, 2);
      tick(1);
      chk("t1_valid_t3", o_ev_valid, 0);
      chk("t1_total", o_total_count, 1);
      chk("t1_busy_t3", o_busy, 0);

      // 2: all lanes at once after reset, round-robin from lane 0, 2-cycle spacing
      @(posedge clk); #1;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      i_lane_det = 4'b1111;
      for (int k = 0; k < 4; k++) exp_q.push_back(k);
      tick(1);
      i_lane_det = '0;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         if (o_ev_valid && nv < 8) begin
            vt[nv] = c;
            nv++;
         end
         tick(1);
      end
      chk("t2_num_events", nv, 4);
      for (int k = 1; k < 4; k++) chk("t2_gap", vt[k] - vt[k-1], 2);
      chk("t2_total", o_total_count, 4);
      chk("t2_queue_empty", exp_q.size(), 0);

      // 3: stall with 9 pulses on lane 1, saturation at 7
      i_ev_ready = 1'b0;
      i_lane_det = 4'b0010;
      tick(9);
      i_lane_det = '0;
      chk("t3_overflow", o_overflow, 4'b0010);
      chk("t3_valid", o_ev_valid, 1);
      chk("t3_lane", o_ev_lane, 1);
      for (int k = 0; k < 7; k++) exp_q.push_back(1);
      i_ev_ready = 1'b1;
      wait_idle(40);
      chk("t3_total", o_total_count, 11);
      chk("t3_queue_empty", exp_q.size(), 0);
      chk("t3_overflow_sticky", o_overflow, 4'b0010);

      // 4: pulse coinciding with accept of the same lane; masked lane 3
      i_lane_det = 4'b0001;
      exp_q.push_back(0);
      tick(1);
      i_lane_det = '0;
      tick(1);
      chk("t4_valid", o_ev_valid, 1);
      chk("t4_lane", o_ev_lane, 0);
      i_lane_det = 4'b1001;
      i_lane_en  = 4'b0111;
      exp_q.push_back(0);
      tick(1);
      i_lane_det = '0;
      i_lane_en  = '1;
      wait_idle(20);
      chk("t4_total", o_total_count, 13);
      chk("t4_queue_empty", exp_q.size(), 0);

      // 5: flush while stalled in OFFER, then flush coinciding with a handshake
      i_ev_ready = 1'b0;
      i_lane_det = 4'b0101;
      tick(1);
      i_lane_det = '0;
      tick(2);
      chk("t5_valid_pre", o_ev_valid, 1);
      chk("t5_lane_pre", o_ev_lane, 2);
      i_flush    = 1'b1;
      i_lane_det = 4'b0001;
      tick(1);
      i_flush    = 1'b0;
      i_lane_det = '0;
      chk("t5_valid_post", o_ev_valid, 0);
      chk("t5_overflow_post", o_overflow, 0);
      chk("t5_busy_post", o_busy, 0);
      chk("t5_total_post", o_total_count, 13);
      tick(3);
      chk("t5_flush_drop", o_ev_valid, 0);
      i_lane_det = 4'b0001;
      exp_q.push_back(0);
      tick(1);
      i_lane_det = '0;
      tick(1);
      i_flush    = 1'b1;
      i_ev_ready = 1'b1;
      tick(1);
      i_flush = 1'b0;
      chk("t5_flush_hs_total", o_total_count, 14);
      chk("t5_flush_hs_valid", o_ev_valid, 0);

      // 6: total_count wrap
      for (int it = 0; it < 1009; it++) begin
         i_lane_det = 4'b0001;
         exp_q.push_back(0);
         tick(1);
         i_lane_det = '0;
         wait_idle(10);
      end
      chk("t6_total_max", o_total_count, 1023);
      i_lane_det = 4'b0001;
      exp_q.push_back(0);
      tick(1);
      i_lane_det = '0;
      wait_idle(10);
      chk("t6_total_wrap", o_total_count, 0);

      // 6b: reset while offering; lane 0 wins first afterwards
      i_ev_ready = 1'b0;
      i_lane_det = 4'b0100;
      tick(1);
      i_lane_det = '0;
      tick(1);
      chk("t6_valid_pre_rst", o_ev_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_rst_valid", o_ev_valid, 0);
      chk("t6_rst_lane", o_ev_lane, 0);
      chk("t6_rst_total", o_total_count, 0);
      chk("t6_rst_busy", o_busy, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      i_ev_ready = 1'b1;
      i_lane_det = 4'b1001;
      exp_q.push_back(0);
      exp_q.push_back(3);
      tick(1);
      i_lane_det = '0;
      wait_idle(20);
      chk("t6_post_total", o_total_count, 2);
      chk("t6_post_queue_empty", exp_q.size(), 0);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
